// File: rtl/ev22_uinst_pkg.sv
// ----------------------------------------------------------------------------
// ev22_uinst_pkg
//   Shared definitions for the EV22 microinstruction word.
//   Layout, MSB first:
//     {busA[5:0], busB[5:0], busC[5:0], ALUC[3:0], SH[1:0], KMx, T[6:0], M[1:0]}
//   Provides field widths and bit offsets, the full word width, the bubble
//   (NOP) word and the "no register" bus select.
// ----------------------------------------------------------------------------
package ev22_uinst_pkg;

  // Field widths
  localparam int BUS_W  = 6;
  localparam int ALUC_W = 4;
  localparam int SH_W   = 2;
  localparam int KMX_W  = 1;
  localparam int T_W    = 7;
  localparam int M_W    = 2;

  // Bit offsets (LSB position of each field)
  localparam int M_OFF    = 0;
  localparam int T_OFF    = M_OFF    + M_W;     // 2
  localparam int KMX_OFF  = T_OFF    + T_W;     // 9
  localparam int SH_OFF   = KMX_OFF  + KMX_W;   // 10
  localparam int ALUC_OFF = SH_OFF   + SH_W;    // 12
  localparam int BUSC_OFF = ALUC_OFF + ALUC_W;  // 16
  localparam int BUSB_OFF = BUSC_OFF + BUS_W;   // 22
  localparam int BUSA_OFF = BUSB_OFF + BUS_W;   // 28

  localparam int UINST_W = BUSA_OFF + BUS_W;    // 34

  // Bus select value meaning "no register drives/loads this bus"
  localparam logic [BUS_W-1:0] BUS_NONE = 6'h3F;

  // Bubble: every bus select is BUS_NONE, every other field is zero
  localparam logic [UINST_W-1:0] UINST_NOP = 34'h3_FFFF_0000;

  // Structured view of the word, field order matches the packed layout
  typedef struct packed {
    logic [BUS_W-1:0]  bus_a;
    logic [BUS_W-1:0]  bus_b;
    logic [BUS_W-1:0]  bus_c;
    logic [ALUC_W-1:0] aluc;
    logic [SH_W-1:0]   sh;
    logic [KMX_W-1:0]  kmx;
    logic [T_W-1:0]    t;
    logic [M_W-1:0]    m;
  } uinst_t;

  // True when a word is the bubble pattern
  function automatic logic is_nop(input logic [UINST_W-1:0] w);
    return w == UINST_NOP;
  endfunction

endpackage

// File: rtl/uinst_pipe_slot.sv
// ----------------------------------------------------------------------------
// uinst_pipe_slot
//   One register stage of the microinstruction chain.
//   Ports:
//     CLK   clock
//     RST   synchronous active-high reset (slot -> NOP, invalid)
//     d     incoming word from the upstream source
//     v_in  valid bit of the incoming word
//     en    capture enable (low = hold)
//     kill  flush: load NOP and clear valid regardless of en
//     q     stored word
//     v     stored valid bit
//   An invalid slot always holds NOP_WORD.
// ----------------------------------------------------------------------------
module uinst_pipe_slot
  import ev22_uinst_pkg::*;
#(
  parameter int               WIDTH    = UINST_W,
  parameter logic [WIDTH-1:0] NOP_WORD = UINST_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  input  logic             en,
  input  logic             kill,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  // NOTE: state is written with non-blocking assignments so every slot
  // samples its neighbour's pre-edge value; blocking here would let a word
  // ripple through several slots in one clock.
  always_ff @(posedge CLK) begin
    if (RST || kill) begin
      q <= NOP_WORD;
      v <= 1'b0;
    end else if (en) begin
      q <= v_in ? d : NOP_WORD;
      v <= v_in;
    end
  end

endmodule

// File: rtl/uinst_pipe_chain.sv
// ----------------------------------------------------------------------------
// uinst_pipe_chain
//   DEPTH-slot microinstruction pipeline with collapsing bubbles, per-slot
//   flush and a saturating stall counter.
//   Ports:
//     CLK, RST      clock, synchronous active-high reset
//     uinst_in      word from decode/sequencer
//     in_valid      uinst_in valid
//     in_ready      slot 0 accepts this cycle
//     STALL         downstream cannot consume the oldest slot
//     FLUSH[k]      kill whatever slot k holds/captures at this edge
//     uinst_out     contents of the oldest slot (DEPTH-1)
//     out_valid     valid bit of the oldest slot
//     stage_valid   valid bits of all slots
//     stall_cycles  saturating count of cycles with out_valid && STALL
// ----------------------------------------------------------------------------
module uinst_pipe_chain
  import ev22_uinst_pkg::*;
#(
  parameter int               WIDTH    = UINST_W,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] NOP_WORD = UINST_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] uinst_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             STALL,
  input  logic [DEPTH-1:0] FLUSH,
  output logic [WIDTH-1:0] uinst_out,
  output logic             out_valid,
  output logic [DEPTH-1:0] stage_valid,
  output logic [15:0]      stall_cycles
);

  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] en;

  // A slot may advance when the downstream drains or any slot from here to
  // the oldest is empty: e[k] = !STALL || !v[k] || ... || !v[DEPTH-1].
  // Accumulating from the oldest slot avoids a self-referencing vector.
  always_comb begin
    logic room;
    // NOTE: combinational temporaries use blocking assignments so each
    // iteration sees the value just computed by the previous one.
    room = !STALL;
    en   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      room  = room || !slot_v[k];
      en[k] = room;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic [WIDTH-1:0] src_d;
    logic             src_v;

    if (k == 0) begin : g_head
      assign src_d = uinst_in;
      assign src_v = in_valid;
    end else begin : g_body
      assign src_d = slot_d[k-1];
      assign src_v = slot_v[k-1];
    end

    uinst_pipe_slot #(
      .WIDTH    (WIDTH),
      .NOP_WORD (NOP_WORD)
    ) u_slot (
      .CLK  (CLK),
      .RST  (RST),
      .d    (src_d),
      .v_in (src_v),
      .en   (en[k]),
      .kill (FLUSH[k]),
      .q    (slot_d[k]),
      .v    (slot_v[k])
    );
  end

  assign in_ready    = en[0];
  assign uinst_out   = slot_d[DEPTH-1];
  assign out_valid   = slot_v[DEPTH-1];
  assign stage_valid = slot_v;

  // Counts on the pre-edge out_valid, so a stall cycle that also flushes the
  // oldest slot is still counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (out_valid && STALL && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_uinst_pipe_chain.sv
// ----------------------------------------------------------------------------
// tb_uinst_pipe_chain
//   Directed bench for uinst_pipe_chain with DEPTH=2: reset, streaming,
//   full stall, bubble collapse, flush of each slot, reset mid-stream and
//   stall counter saturation.
// ----------------------------------------------------------------------------
module tb_uinst_pipe_chain;

  localparam int DEPTH = 2;
  localparam int W     = 34;
  localparam logic [W-1:0] NOP = 34'h3_FFFF_0000;

  localparam logic [W-1:0] A = 34'h0_1111_1111;
  localparam logic [W-1:0] B = 34'h1_2222_2222;
  localparam logic [W-1:0] C = 34'h2_3333_3333;
  localparam logic [W-1:0] D = 34'h0_4444_4444;

  logic             CLK = 1'b0;
  logic             RST;
  logic [W-1:0]     uinst_in;
  logic             in_valid;
  logic             in_ready;
  logic             STALL;
  logic [DEPTH-1:0] FLUSH;
  logic [W-1:0]     uinst_out;
  logic             out_valid;
  logic [DEPTH-1:0] stage_valid;
  logic [15:0]      stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uinst_pipe_chain #(
    .WIDTH    (W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .uinst_in     (uinst_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .STALL        (STALL),
    .FLUSH        (FLUSH),
    .uinst_out    (uinst_out),
    .out_valid    (out_valid),
    .stage_valid  (stage_valid),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; uinst_in = '0; in_valid = 1'b0; STALL = 1'b0; FLUSH = '0;
    step();

    // Reset state
    check("rst_out",   uinst_out,    NOP);
    check("rst_ov",    out_valid,    1'b0);
    check("rst_sv",    stage_valid,  2'b00);
    check("rst_cnt",   stall_cycles, 16'd0);
    RST = 1'b0;
    check("rst_rdy",   in_ready,     1'b1);

    // Stream A, B, C with no stalls: A appears after the second edge
    in_valid = 1'b1; uinst_in = A;
    step();
    check("s_rdy_a",   in_ready,     1'b1);
    uinst_in = B;
    step();
    check("s_out_a",   uinst_out,    A);
    check("s_ov_a",    out_valid,    1'b1);
    check("s_rdy_b",   in_ready,     1'b1);
    uinst_in = C;
    step();
    check("s_out_b",   uinst_out,    B);
    in_valid = 1'b0;
    step();
    check("s_out_c",   uinst_out,    C);
    check("s_sv_c",    stage_valid,  2'b10);
    step();
    check("s_empty_o", uinst_out,    NOP);
    check("s_empty_v", out_valid,    1'b0);

    // Full stall: A oldest, B younger, C pending
    in_valid = 1'b1; uinst_in = A;
    step();
    uinst_in = B;
    step();
    uinst_in = C; STALL = 1'b1;
    #1;
    check("fs_rdy0",   in_ready,     1'b0);
    for (int i = 0; i < 5; i++) step();
    check("fs_out",    uinst_out,    A);
    check("fs_sv",     stage_valid,  2'b11);
    check("fs_rdy",    in_ready,     1'b0);
    check("fs_cnt",    stall_cycles, 16'd5);
    STALL = 1'b0;
    #1;
    check("fs_rel_rdy", in_ready,    1'b1);
    step();
    check("fs_out_b",  uinst_out,    B);
    in_valid = 1'b0;
    step();
    check("fs_out_c",  uinst_out,    C);
    step();
    check("fs_drain",  out_valid,    1'b0);
    check("fs_cnt2",   stall_cycles, 16'd5);

    // Bubble collapse: slot 1 = A, slot 0 empty, STALL held
    in_valid = 1'b1; uinst_in = A;
    step();
    in_valid = 1'b0;
    step();
    check("bc_sv0",    stage_valid,  2'b10);
    STALL = 1'b1; in_valid = 1'b1; uinst_in = B;
    #1;
    check("bc_rdy",    in_ready,     1'b1);
    step();
    check("bc_sv",     stage_valid,  2'b11);
    check("bc_out",    uinst_out,    A);
    check("bc_cnt",    stall_cycles, 16'd6);
    uinst_in = C;
    #1;
    check("bc_rdy2",   in_ready,     1'b0);
    STALL = 1'b0;
    step();
    check("bc_out_b",  uinst_out,    B);
    in_valid = 1'b0;
    step();
    check("bc_out_c",  uinst_out,    C);
    step();
    check("bc_drain",  stage_valid,  2'b00);

    // Flush slot 0 while C is accepted: C dropped, B delivered, no C
    in_valid = 1'b1; uinst_in = A;
    step();
    uinst_in = B;
    step();
    check("fl_out_a",  uinst_out,    A);
    uinst_in = C; FLUSH = 2'b01;
    #1;
    check("fl_rdy",    in_ready,     1'b1);
    step();
    check("fl_out_b",  uinst_out,    B);
    check("fl_sv",     stage_valid,  2'b10);
    FLUSH = 2'b00; in_valid = 1'b0;
    step();
    check("fl_no_c_v", out_valid,    1'b0);
    check("fl_no_c_o", uinst_out,    NOP);

    // Flush oldest slot during STALL: cleared, still counted, B holds then moves
    in_valid = 1'b1; uinst_in = A;
    step();
    uinst_in = B;
    step();
    in_valid = 1'b0; STALL = 1'b1; FLUSH = 2'b10;
    step();
    check("f1_ov",     out_valid,    1'b0);
    check("f1_out",    uinst_out,    NOP);
    check("f1_sv",     stage_valid,  2'b01);
    check("f1_cnt",    stall_cycles, 16'd7);
    FLUSH = 2'b00;
    step();
    check("f1_out_b",  uinst_out,    B);
    check("f1_cnt2",   stall_cycles, 16'd7);

    // Reset mid-stream with both slots valid and STALL high
    in_valid = 1'b1; uinst_in = D;
    step();
    check("rm_sv",     stage_valid,  2'b11);
    check("rm_cnt",    stall_cycles, 16'd8);
    RST = 1'b1;
    step();
    check("rm_out",    uinst_out,    NOP);
    check("rm_ov",     out_valid,    1'b0);
    check("rm_sv2",    stage_valid,  2'b00);
    check("rm_cnt2",   stall_cycles, 16'd0);
    RST = 1'b0; in_valid = 1'b0;
    #1;
    check("rm_rdy",    in_ready,     1'b1);

    // Saturation: hold A in the oldest slot under STALL for 65540 cycles
    STALL = 1'b0; in_valid = 1'b1; uinst_in = A;
    step();
    in_valid = 1'b0;
    step();
    STALL = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    check("sat_fffe",  stall_cycles, 16'hFFFE);
    step();
    check("sat_ffff",  stall_cycles, 16'hFFFF);
    for (int i = 0; i < 5; i++) step();
    check("sat_hold",  stall_cycles, 16'hFFFF);
    check("sat_out",   uinst_out,    A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
